// File: rtl/ts_mm_host_sequencer.sv
// Register-port initiator for the TS QoS channel-control block: loads a configuration
// set over mm_*, then polls the status and error-count registers every POLL_PERIOD cycles.
module ts_mm_host_sequencer #(
  parameter int unsigned POLL_PERIOD   = 1000,
  parameter int unsigned READ_LATENCY  = 1,
  parameter logic [7:0]  ADDR_CTRL     = 8'h00,
  parameter logic [7:0]  ADDR_PRIORITY = 8'h04,
  parameter logic [7:0]  ADDR_TIMER    = 8'h08,
  parameter logic [7:0]  ADDR_COMMIT   = 8'h0C,
  parameter logic [7:0]  ADDR_STATUS   = 8'h10,
  parameter logic [7:0]  ADDR_ERR      = 8'h14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cfg_fallback_enable,
  input  logic        cfg_manual_enable,
  input  logic [1:0]  cfg_manual_channel,
  input  logic [7:0]  cfg_channel_priority,
  input  logic [19:0] cfg_reset_timer,
  output logic        busy,
  output logic        cfg_done,
  output logic        mm_write_en,
  output logic        mm_read_en,
  output logic [7:0]  mm_addr,
  output logic [31:0] mm_wdata,
  input  logic [31:0] mm_rdata,
  output logic [1:0]  stat_active_channel,
  output logic [3:0]  stat_signal_present,
  output logic [31:0] stat_err_count,
  output logic        stat_valid
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_POLL_WAIT, S_RD_STATUS, S_RD_ERR} state_t;

  localparam logic [19:0] POLL_LAST = 20'(POLL_PERIOD - 1);
  localparam logic [1:0]  RD_LAST   = 2'(READ_LATENCY);

  state_t      state_q;
  logic [1:0]  wr_idx_q;
  logic [19:0] cnt_q;
  logic [1:0]  lat_q;

  logic        sh_fb_q, sh_me_q;
  logic [1:0]  sh_mc_q;
  logic [7:0]  sh_pri_q;
  logic [19:0] sh_tmr_q;

  logic        pend_q;
  logic        pend_fb_q, pend_me_q;
  logic [1:0]  pend_mc_q;
  logic [7:0]  pend_pri_q;
  logic [19:0] pend_tmr_q;

  logic [1:0]  st_ch_q;
  logic [3:0]  st_sp_q;

  logic        busy_q, done_q, we_q, re_q, sv_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q, err_q;
  logic [1:0]  ch_q;
  logic [3:0]  sp_q;

  logic        ld_fb_d, ld_me_d;
  logic [1:0]  ld_mc_d;
  logic [7:0]  ld_pri_d;
  logic [19:0] ld_tmr_d;

  // A new load takes the pending slot if one is held, otherwise the live cfg inputs.
  always_comb begin
    ld_fb_d  = cfg_fallback_enable;
    ld_me_d  = cfg_manual_enable;
    ld_mc_d  = cfg_manual_channel;
    ld_pri_d = cfg_channel_priority;
    ld_tmr_d = cfg_reset_timer;
    if (pend_q) begin
      ld_fb_d  = pend_fb_q;
      ld_me_d  = pend_me_q;
      ld_mc_d  = pend_mc_q;
      ld_pri_d = pend_pri_q;
      ld_tmr_d = pend_tmr_q;
    end
  end

  function automatic logic [7:0] wr_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    return ADDR_CTRL;
      2'd1:    return ADDR_PRIORITY;
      2'd2:    return ADDR_TIMER;
      default: return ADDR_COMMIT;
    endcase
  endfunction

  function automatic logic [31:0] wr_word(input logic [1:0] idx, input logic fb, input logic me,
                                          input logic [1:0] mc, input logic [7:0] pri,
                                          input logic [19:0] tmr);
    case (idx)
      2'd0:    return {28'd0, mc, me, fb};
      2'd1:    return {24'd0, pri};
      2'd2:    return {12'd0, tmr};
      default: return 32'h1;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_idx_q <= 2'd0;
      cnt_q    <= 20'd0;
      lat_q    <= 2'd0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      addr_q   <= 8'd0;
      wdata_q  <= 32'd0;
      ch_q     <= 2'd0;
      sp_q     <= 4'd0;
      err_q    <= 32'd0;
      sv_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 32'd0;
      sv_q    <= 1'b0;
      case (state_q)
        S_IDLE, S_POLL_WAIT: begin
          if (start) begin
            {sh_fb_q, sh_me_q, sh_mc_q, sh_pri_q, sh_tmr_q} <= {ld_fb_d, ld_me_d, ld_mc_d, ld_pri_d, ld_tmr_d};
            we_q     <= 1'b1;
            addr_q   <= wr_addr(2'd0);
            wdata_q  <= wr_word(2'd0, ld_fb_d, ld_me_d, ld_mc_d, ld_pri_d, ld_tmr_d);
            wr_idx_q <= 2'd0;
            busy_q   <= 1'b1;
            state_q  <= S_WRITE;
          end else begin
            busy_q <= 1'b0;
            if (state_q == S_POLL_WAIT) begin
              if (cnt_q == POLL_LAST) begin
                re_q    <= 1'b1;
                addr_q  <= ADDR_STATUS;
                lat_q   <= 2'd0;
                state_q <= S_RD_STATUS;
              end else begin
                cnt_q <= cnt_q + 20'd1;
              end
            end
          end
        end
        S_WRITE: begin
          if (wr_idx_q == 2'd3) begin
            done_q  <= 1'b1;
            cnt_q   <= 20'd0;
            state_q <= S_POLL_WAIT;
          end else begin
            we_q     <= 1'b1;
            addr_q   <= wr_addr(wr_idx_q + 2'd1);
            wdata_q  <= wr_word(wr_idx_q + 2'd1, sh_fb_q, sh_me_q, sh_mc_q, sh_pri_q, sh_tmr_q);
            wr_idx_q <= wr_idx_q + 2'd1;
          end
        end
        S_RD_STATUS: begin
          if (start && !pend_q) begin
            pend_q <= 1'b1;
            {pend_fb_q, pend_me_q, pend_mc_q, pend_pri_q, pend_tmr_q} <= {cfg_fallback_enable,
              cfg_manual_enable, cfg_manual_channel, cfg_channel_priority, cfg_reset_timer};
            busy_q <= 1'b1;
          end
          if (lat_q == RD_LAST) begin
            st_ch_q <= mm_rdata[1:0];
            st_sp_q <= mm_rdata[7:4];
            re_q    <= 1'b1;
            addr_q  <= ADDR_ERR;
            lat_q   <= 2'd0;
            state_q <= S_RD_ERR;
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        S_RD_ERR: begin
          if (lat_q == RD_LAST) begin
            ch_q  <= st_ch_q;
            sp_q  <= st_sp_q;
            err_q <= mm_rdata;
            sv_q  <= 1'b1;
            // A start seen on the capture cycle itself is loaded straight from the inputs.
            if (pend_q || start) begin
              {sh_fb_q, sh_me_q, sh_mc_q, sh_pri_q, sh_tmr_q} <= {ld_fb_d, ld_me_d, ld_mc_d, ld_pri_d, ld_tmr_d};
              we_q     <= 1'b1;
              addr_q   <= wr_addr(2'd0);
              wdata_q  <= wr_word(2'd0, ld_fb_d, ld_me_d, ld_mc_d, ld_pri_d, ld_tmr_d);
              wr_idx_q <= 2'd0;
              pend_q   <= 1'b0;
              busy_q   <= 1'b1;
              state_q  <= S_WRITE;
            end else begin
              cnt_q   <= 20'd0;
              state_q <= S_POLL_WAIT;
            end
          end else begin
            if (start && !pend_q) begin
              pend_q <= 1'b1;
              {pend_fb_q, pend_me_q, pend_mc_q, pend_pri_q, pend_tmr_q} <= {cfg_fallback_enable,
                cfg_manual_enable, cfg_manual_channel, cfg_channel_priority, cfg_reset_timer};
              busy_q <= 1'b1;
            end
            lat_q <= lat_q + 2'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy                = busy_q;
  assign cfg_done            = done_q;
  assign mm_write_en         = we_q;
  assign mm_read_en          = re_q;
  assign mm_addr             = addr_q;
  assign mm_wdata            = wdata_q;
  assign stat_active_channel = ch_q;
  assign stat_signal_present = sp_q;
  assign stat_err_count      = err_q;
  assign stat_valid          = sv_q;

endmodule

// File: tb/tb_ts_mm_host_sequencer.sv
// Bench for ts_mm_host_sequencer: scoreboarded writes/reads/status for a READ_LATENCY=1
// instance, plus a READ_LATENCY=3 instance checked cycle by cycle.
module tb_ts_mm_host_sequencer;
  localparam int P = 4;
  localparam logic [7:0] A_STATUS = 8'h10;

  typedef struct { int c; logic [7:0] addr; logic [31:0] data; } bus_t;
  typedef struct { int c; logic [1:0] ch; logic [3:0] sp; logic [31:0] err; } stat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int next_r = 0;

  logic a_rst = 1'b1, a_start = 1'b0, a_fb = 1'b0, a_me = 1'b0;
  logic [1:0] a_mc = 2'd0; logic [7:0] a_pri = 8'd0; logic [19:0] a_tmr = 20'd0;
  logic a_busy, a_done, a_we, a_re, a_sv;
  logic [7:0] a_addr; logic [31:0] a_wdata, a_err; logic [31:0] a_rdata = 32'd0;
  logic [1:0] a_ch; logic [3:0] a_sp;

  logic b_rst = 1'b1, b_start = 1'b0, b_fb = 1'b0, b_me = 1'b0;
  logic [1:0] b_mc = 2'd0; logic [7:0] b_pri = 8'd0; logic [19:0] b_tmr = 20'd0;
  logic b_busy, b_done, b_we, b_re, b_sv;
  logic [7:0] b_addr; logic [31:0] b_wdata, b_err; logic [31:0] b_rdata = 32'd0;
  logic [1:0] b_ch; logic [3:0] b_sp;

  ts_mm_host_sequencer #(.POLL_PERIOD(P), .READ_LATENCY(1)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .cfg_fallback_enable(a_fb), .cfg_manual_enable(a_me),
    .cfg_manual_channel(a_mc), .cfg_channel_priority(a_pri), .cfg_reset_timer(a_tmr),
    .busy(a_busy), .cfg_done(a_done), .mm_write_en(a_we), .mm_read_en(a_re), .mm_addr(a_addr),
    .mm_wdata(a_wdata), .mm_rdata(a_rdata), .stat_active_channel(a_ch),
    .stat_signal_present(a_sp), .stat_err_count(a_err), .stat_valid(a_sv));

  ts_mm_host_sequencer #(.POLL_PERIOD(P), .READ_LATENCY(3)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .cfg_fallback_enable(b_fb), .cfg_manual_enable(b_me),
    .cfg_manual_channel(b_mc), .cfg_channel_priority(b_pri), .cfg_reset_timer(b_tmr),
    .busy(b_busy), .cfg_done(b_done), .mm_write_en(b_we), .mm_read_en(b_re), .mm_addr(b_addr),
    .mm_wdata(b_wdata), .mm_rdata(b_rdata), .stat_active_channel(b_ch),
    .stat_signal_present(b_sp), .stat_err_count(b_err), .stat_valid(b_sv));

  // Register-port responders: correct data only on the due cycle, bit-inverted decoy otherwise.
  logic [31:0] a_status_val = 32'd0, a_err_val = 32'd0, b_status_val = 32'd0, b_err_val = 32'd0;
  int a_due = -1, b_due = -1;
  logic [7:0] a_due_addr = 8'd0, b_due_addr = 8'd0;
  always @(negedge clk) begin
    if (a_re) begin a_due = cyc + 1; a_due_addr = a_addr; end
    if (cyc == a_due) a_rdata = (a_due_addr == A_STATUS) ? a_status_val : a_err_val;
    else              a_rdata = ~((a_due_addr == A_STATUS) ? a_status_val : a_err_val);
    if (b_re) begin b_due = cyc + 3; b_due_addr = b_addr; end
    if (cyc == b_due) b_rdata = (b_due_addr == A_STATUS) ? b_status_val : b_err_val;
    else              b_rdata = ~((b_due_addr == A_STATUS) ? b_status_val : b_err_val);
  end

  bus_t exp_wr[$];
  bus_t exp_rd[$];
  stat_t exp_st[$];
  int exp_done[$];

  function automatic void push_cfg(int c0, logic fb, logic me, logic [1:0] mc, logic [7:0] pri,
                                   logic [19:0] tmr);
    bus_t e;
    e.c = c0;     e.addr = 8'h00; e.data = {28'd0, mc, me, fb}; exp_wr.push_back(e);
    e.c = c0 + 1; e.addr = 8'h04; e.data = {24'd0, pri};         exp_wr.push_back(e);
    e.c = c0 + 2; e.addr = 8'h08; e.data = {12'd0, tmr};         exp_wr.push_back(e);
    e.c = c0 + 3; e.addr = 8'h0C; e.data = 32'h1;                exp_wr.push_back(e);
    exp_done.push_back(c0 + 4);
  endfunction

  function automatic void push_poll(int r, logic [31:0] st, logic [31:0] er, bit with_stat);
    bus_t e;
    stat_t s;
    e.c = r;     e.addr = 8'h10; e.data = 32'd0; exp_rd.push_back(e);
    e.c = r + 2; e.addr = 8'h14; e.data = 32'd0; exp_rd.push_back(e);
    if (with_stat) begin
      s.c = r + 4; s.ch = st[1:0]; s.sp = st[7:4]; s.err = er;
      exp_st.push_back(s);
    end
  endfunction

  bus_t mw, mr;
  stat_t ms;
  int md;
  always @(negedge clk) begin
    checks++;
    if ((a_we && a_re) || (!a_we && !a_re && (a_addr !== 8'h0 || a_wdata !== 32'h0))) begin
      errors++;
      $display("FAIL bus_idle cyc=%0d we=%b re=%b addr=%h wdata=%h, required exclusive strobes and zero idle bus",
               cyc, a_we, a_re, a_addr, a_wdata);
    end
    if (a_we || (exp_wr.size() > 0 && exp_wr[0].c < cyc)) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected cyc=%0d addr=%h data=%h, required no write", cyc, a_addr, a_wdata);
      end else begin
        mw = exp_wr.pop_front();
        if (!a_we || cyc !== mw.c || a_addr !== mw.addr || a_wdata !== mw.data) begin
          errors++;
          $display("FAIL write got we=%b cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%h",
                   a_we, cyc, a_addr, a_wdata, mw.c, mw.addr, mw.data);
        end
      end
    end
    if (a_re || (exp_rd.size() > 0 && exp_rd[0].c < cyc)) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected cyc=%0d addr=%h, required no read", cyc, a_addr);
      end else begin
        mr = exp_rd.pop_front();
        if (!a_re || cyc !== mr.c || a_addr !== mr.addr) begin
          errors++;
          $display("FAIL read got re=%b cyc=%0d addr=%h, required cyc=%0d addr=%h",
                   a_re, cyc, a_addr, mr.c, mr.addr);
        end
      end
    end
    if (a_done || (exp_done.size() > 0 && exp_done[0] < cyc)) begin
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL cfg_done_unexpected cyc=%0d, required no pulse", cyc);
      end else begin
        md = exp_done.pop_front();
        if (!a_done || cyc !== md) begin
          errors++;
          $display("FAIL cfg_done got pulse=%b cyc=%0d, required cyc=%0d", a_done, cyc, md);
        end
      end
    end
    if (a_sv || (exp_st.size() > 0 && exp_st[0].c < cyc)) begin
      checks++;
      if (exp_st.size() == 0) begin
        errors++;
        $display("FAIL stat_unexpected cyc=%0d, required no stat_valid", cyc);
      end else begin
        ms = exp_st.pop_front();
        if (!a_sv || cyc !== ms.c || a_ch !== ms.ch || a_sp !== ms.sp || a_err !== ms.err) begin
          errors++;
          $display("FAIL stat got sv=%b cyc=%0d ch=%0d sp=%h err=%h, required cyc=%0d ch=%0d sp=%h err=%h",
                   a_sv, cyc, a_ch, a_sp, a_err, ms.c, ms.ch, ms.sp, ms.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(logic fb, logic me, logic [1:0] mc, logic [7:0] pri, logic [19:0] tmr);
    a_start = 1'b1; a_fb = fb; a_me = me; a_mc = mc; a_pri = pri; a_tmr = tmr;
  endtask

  task automatic test_reset();
    a_rst = 1'b1;
    a_start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_we, a_re, a_addr, a_wdata} !== 44'd0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b done=%b we=%b re=%b addr=%h wdata=%h, required all 0",
               a_busy, a_done, a_we, a_re, a_addr, a_wdata);
    end
    checks++;
    if ({a_ch, a_sp, a_err, a_sv} !== 39'd0) begin
      errors++;
      $display("FAIL reset_stat ch=%0d sp=%h err=%h sv=%b, required all 0", a_ch, a_sp, a_err, a_sv);
    end
    tick();
    a_rst = 1'b0;
    repeat (3 * P) tick();
    @(negedge clk);
    checks++;
    if ({a_busy, a_we, a_re} !== 3'b000) begin
      errors++;
      $display("FAIL idle_no_poll busy=%b we=%b re=%b, required 000", a_busy, a_we, a_re);
    end
  endtask

  task automatic test_config_and_poll();
    int t, c, r1, r2;
    logic eb;
    tick();
    t = cyc;
    c = t + 5;
    r1 = c + P;
    r2 = r1 + 4 + P;
    a_status_val = 32'h0000_00B2;
    a_err_val    = 32'h0403_0201;
    push_cfg(t + 1, 1'b1, 1'b0, 2'd2, 8'hE4, 20'd50);
    push_poll(r1, a_status_val, a_err_val, 1'b1);
    push_poll(r2, a_status_val, a_err_val, 1'b1);
    a_drive(1'b1, 1'b0, 2'd2, 8'hE4, 20'd50);
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_before_accept got %b, required 0", a_busy);
    end
    tick();
    a_start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      eb = (i <= 5);
      checks++;
      if (a_busy !== eb) begin
        errors++;
        $display("FAIL busy_cfg at T+%0d got %b, required %b", i, a_busy, eb);
      end
      tick();
    end
    while (cyc < r2 + 5) tick();
    @(negedge clk);
    checks++;
    if ({a_ch, a_sp, a_err, a_sv} !== {2'd2, 4'hB, 32'h0403_0201, 1'b0}) begin
      errors++;
      $display("FAIL stat_hold ch=%0d sp=%h err=%h sv=%b, required ch=2 sp=b err=04030201 sv=0",
               a_ch, a_sp, a_err, a_sv);
    end
    next_r = r2 + 4 + P;
  endtask

  task automatic test_start_during_read();
    int r, v;
    logic eb;
    r = next_r;
    v = r + 4;
    a_status_val = 32'h0000_0051;
    a_err_val    = 32'h1122_3344;
    push_poll(r, a_status_val, a_err_val, 1'b1);
    push_cfg(v, 1'b0, 1'b1, 2'd3, 8'h5A, 20'hFFFFF);
    while (cyc < r) tick();
    a_drive(1'b0, 1'b1, 2'd3, 8'h5A, 20'hFFFFF);
    tick();
    a_start = 1'b0;
    while (cyc <= v + 5) begin
      if (cyc == r + 2 || cyc == v + 1) a_drive(1'b1, 1'b0, 2'd1, 8'h11, 20'h12345);
      @(negedge clk);
      eb = (cyc <= v + 4);
      checks++;
      if (a_busy !== eb) begin
        errors++;
        $display("FAIL busy_pending cyc=%0d got %b, required %b", cyc, a_busy, eb);
      end
      tick();
      a_start = 1'b0;
    end
    next_r = v + 4 + P;
  endtask

  task automatic test_reset_during_err();
    int r;
    r = next_r;
    push_poll(r, a_status_val, a_err_val, 1'b0);
    while (cyc < r + 2) tick();
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_we, a_re, a_addr, a_wdata} !== 44'd0) begin
      errors++;
      $display("FAIL abort_ctrl busy=%b done=%b we=%b re=%b addr=%h wdata=%h, required all 0",
               a_busy, a_done, a_we, a_re, a_addr, a_wdata);
    end
    checks++;
    if ({a_ch, a_sp, a_err, a_sv} !== 39'd0) begin
      errors++;
      $display("FAIL abort_stat ch=%0d sp=%h err=%h sv=%b, required all 0", a_ch, a_sp, a_err, a_sv);
    end
    repeat (3 * P + 4) tick();
    @(negedge clk);
    checks++;
    if (exp_wr.size() + exp_rd.size() + exp_st.size() + exp_done.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations wr=%0d rd=%0d st=%0d done=%0d, required 0",
               exp_wr.size(), exp_rd.size(), exp_st.size(), exp_done.size());
    end
  endtask

  task automatic test_read_latency3();
    int t, r;
    logic [3:0] ev;
    b_status_val = 32'h0000_00C3;
    b_err_val    = 32'hA1B2_C3D4;
    tick();
    b_rst = 1'b0;
    tick();
    t = cyc;
    r = t + 5 + P;
    b_start = 1'b1; b_fb = 1'b1; b_me = 1'b1; b_mc = 2'd1; b_pri = 8'h80; b_tmr = 20'hABCDE;
    while (cyc <= r + 9) begin
      @(negedge clk);
      ev[3] = (cyc >= t + 1 && cyc <= t + 4);
      ev[2] = (cyc == t + 5);
      ev[1] = (cyc == r || cyc == r + 4);
      ev[0] = (cyc == r + 8);
      checks++;
      if ({b_we, b_done, b_re, b_sv} !== ev) begin
        errors++;
        $display("FAIL lat3_strobes cyc=%0d we/done/re/sv=%b, required %b", cyc,
                 {b_we, b_done, b_re, b_sv}, ev);
      end
      if (cyc == r + 8) begin
        checks++;
        if ({b_ch, b_sp, b_err} !== {2'd3, 4'hC, 32'hA1B2_C3D4}) begin
          errors++;
          $display("FAIL lat3_stat ch=%0d sp=%h err=%h, required ch=3 sp=c err=a1b2c3d4",
                   b_ch, b_sp, b_err);
        end
      end
      tick();
      b_start = 1'b0;
    end
    b_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_config_and_poll();
    test_start_during_read();
    test_reset_during_err();
    test_read_latency3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
